// File: rtl/cache_pkg.sv
// Shared definitions for the cache refill/write-back port: request type codes,
// line geometry and the responder state encoding.
package cache_pkg;

  localparam logic [2:0] T_BYTE = 3'b000;
  localparam logic [2:0] T_HALF = 3'b001;
  localparam logic [2:0] T_WORD = 3'b010;
  localparam logic [2:0] T_LINE = 3'b100;

  localparam int LINE_WORDS = 4;
  localparam int LINE_BYTES = 16;
  localparam int LINE_OFF_W = $clog2(LINE_BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_BEAT,
    S_WR
  } state_t;

  function automatic logic type_legal(input logic [2:0] t);
    return (t == T_BYTE) || (t == T_HALF) || (t == T_WORD) || (t == T_LINE);
  endfunction

endpackage

// File: rtl/resp_ram.sv
// Single-port synchronous word RAM with byte enables; read data appears one
// cycle after the address (read-first on a simultaneous write).
module resp_ram #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    rdata <= mem[addr];
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for one cache port: serialises reads and writes through IDLE,
// returns 1 or 4 read beats RD_LAT cycles after accept, writes take 1 or 4 cycles.
module cache_mem_responder
  import cache_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic         err
);

  localparam logic [1:0] LAST_BEAT = 2'(LINE_WORDS - 1);
  localparam logic [3:0] LAT_END   = 4'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

  state_t              state, state_nx;
  logic [1:0]          beat_q;
  logic [3:0]          lat_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                line_q;
  logic [127:0]        wdata_q;
  logic [3:0]          wstrb_q;

  logic [ADDR_W-1:0]   rd_word, wr_word;
  logic                rd_acc, wr_acc, last;

  logic                ram_we;
  logic [3:0]          ram_be;
  logic [ADDR_W-1:0]   ram_addr;
  logic [31:0]         ram_wdata, ram_rdata;

  logic                unused_addr_bits;
  assign unused_addr_bits = ^{rd_addr[31:ADDR_W+2], rd_addr[1:0],
                              wr_addr[31:ADDR_W+2], wr_addr[1:0]};

  // Line requests are aligned down to the first word of the line.
  assign rd_word = (rd_type == T_LINE) ? {rd_addr[ADDR_W+1:LINE_OFF_W], 2'b00}
                                       : rd_addr[ADDR_W+1:2];
  assign wr_word = (wr_type == T_LINE) ? {wr_addr[ADDR_W+1:LINE_OFF_W], 2'b00}
                                       : wr_addr[ADDR_W+1:2];

  assign wr_rdy = (state == S_IDLE);
  assign rd_rdy = (state == S_IDLE) && !wr_req;
  assign wr_acc = wr_req && wr_rdy;
  assign rd_acc = rd_req && rd_rdy;
  assign last   = !line_q || (beat_q == LAST_BEAT);

  assign ret_valid = (state == S_RD_BEAT);
  assign ret_last  = ret_valid && last;
  assign ret_data  = ret_valid ? ram_rdata : 32'd0;

  // The RAM is read every cycle; the address presented is always the word
  // that the following cycle's beat must carry.
  always_comb begin
    state_nx  = state;
    ram_we    = 1'b0;
    ram_be    = 4'h0;
    ram_addr  = addr_q;
    ram_wdata = wdata_q[{beat_q, 5'd0} +: 32];
    case (state)
      S_IDLE: begin
        ram_addr = rd_word;
        if (wr_req)      state_nx = S_WR;
        else if (rd_req) state_nx = (RD_LAT == 1) ? S_RD_BEAT : S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (lat_q == LAT_END) state_nx = S_RD_BEAT;
      end
      S_RD_BEAT: begin
        ram_addr = {addr_q[ADDR_W-1:2], beat_q + 2'd1};
        if (last) state_nx = S_IDLE;
      end
      S_WR: begin
        ram_we   = 1'b1;
        ram_be   = line_q ? 4'hF : wstrb_q;
        ram_addr = line_q ? {addr_q[ADDR_W-1:2], beat_q} : addr_q;
        if (last) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      beat_q <= 2'd0;
      lat_q  <= 4'd0;
      err    <= 1'b0;
    end else begin
      state <= state_nx;
      if (wr_acc) begin
        addr_q  <= wr_word;
        line_q  <= (wr_type == T_LINE);
        wdata_q <= wr_data;
        wstrb_q <= wr_wstrb;
        if (!type_legal(wr_type)) err <= 1'b1;
      end else if (rd_acc) begin
        addr_q <= rd_word;
        line_q <= (rd_type == T_LINE);
        if (!type_legal(rd_type)) err <= 1'b1;
      end
      if ((state == S_RD_BEAT) || (state == S_WR)) beat_q <= last ? 2'd0 : beat_q + 2'd1;
      lat_q <= (state == S_RD_WAIT) ? lat_q + 4'd1 : 4'd0;
    end
  end

  resp_ram #(.AW(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: line/word reads and writes, priority,
// reset mid-burst and sticky error.
module tb_cache_mem_responder;
  localparam int RD_LAT = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic         err;

  int ncmp  = 0;
  int nfail = 0;

  cache_mem_responder #(.ADDR_W(12), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_req    (rd_req),
    .rd_type   (rd_type),
    .rd_addr   (rd_addr),
    .rd_rdy    (rd_rdy),
    .ret_valid (ret_valid),
    .ret_last  (ret_last),
    .ret_data  (ret_data),
    .wr_req    (wr_req),
    .wr_type   (wr_type),
    .wr_addr   (wr_addr),
    .wr_wstrb  (wr_wstrb),
    .wr_data   (wr_data),
    .wr_rdy    (wr_rdy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a write from IDLE and wait (bounded) until the responder is idle again.
  task automatic do_wr(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                       input logic [127:0] d);
    wr_type = t; wr_addr = a; wr_wstrb = s; wr_data = d; wr_req = 1'b1;
    step();
    wr_req = 1'b0;
    for (int i = 0; i < 10 && !wr_rdy; i++) step();
    check("wr_done", {31'd0, wr_rdy}, 32'd1);
  endtask

  // Issue a read in the current cycle T and check every cycle up to T+RD_LAT+n.
  task automatic read_chk(input string tag, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3, input int n);
    logic [31:0] exp [4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    rd_type = t; rd_addr = a; rd_req = 1'b1;
    #1;
    check({tag, "_rd_rdy"}, {31'd0, rd_rdy}, 32'd1);
    step();
    rd_req = 1'b0;
    for (int c = 1; c < RD_LAT; c++) begin
      check({tag, "_wait_vld"}, {31'd0, ret_valid}, 32'd0);
      step();
    end
    for (int b = 0; b < n; b++) begin
      check({tag, "_vld"}, {31'd0, ret_valid}, 32'd1);
      check({tag, "_data"}, ret_data, exp[b]);
      check({tag, "_last"}, {31'd0, ret_last}, {31'd0, (b == n - 1)});
      step();
    end
    check({tag, "_end_vld"}, {31'd0, ret_valid}, 32'd0);
    check({tag, "_end_rdy"}, {31'd0, rd_rdy}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; rd_req = 1'b0; rd_type = 3'b000; rd_addr = 32'd0;
    wr_req = 1'b0; wr_type = 3'b000; wr_addr = 32'd0; wr_wstrb = 4'h0; wr_data = '0;
    step(); step();
    reset = 1'b0;

    // Reset state
    check("rst_wr_rdy", {31'd0, wr_rdy}, 32'd1);
    check("rst_rd_rdy", {31'd0, rd_rdy}, 32'd1);
    check("rst_ret_valid", {31'd0, ret_valid}, 32'd0);
    check("rst_ret_last", {31'd0, ret_last}, 32'd0);
    check("rst_ret_data", ret_data, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    wr_req = 1'b1;
    #1;
    check("rst_rd_rdy_wr", {31'd0, rd_rdy}, 32'd0);
    wr_req = 1'b0;
    #1;

    // Preload 0x100..0x10C and read the line from a mid-line address
    do_wr(3'b100, 32'h100, 4'h0, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    read_chk("line108", 3'b100, 32'h108, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4);

    // Line write with ready timing, then read back
    wr_type = 3'b100; wr_addr = 32'h200; wr_wstrb = 4'h0;
    wr_data = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
    wr_req = 1'b1;
    #1;
    check("lw_rdy_T", {31'd0, wr_rdy}, 32'd1);
    step();
    wr_req = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check("lw_busy", {31'd0, wr_rdy}, 32'd0);
      step();
    end
    check("lw_rdy_T5", {31'd0, wr_rdy}, 32'd1);
    read_chk("line200", 3'b100, 32'h200, 32'hD000_0000, 32'hD000_0001,
             32'hD000_0002, 32'hD000_0003, 4);

    // Byte write merge into an existing word
    do_wr(3'b010, 32'h300, 4'hF, {96'd0, 32'h1122_3344});
    do_wr(3'b000, 32'h302, 4'b0100, {96'd0, 32'h00AA_0000});
    read_chk("byte_merge", 3'b010, 32'h300, 32'h11AA_3344, 32'h0, 32'h0, 32'h0, 1);

    // Simultaneous requests: write wins, read follows after IDLE returns
    do_wr(3'b010, 32'h304, 4'hF, {96'd0, 32'h0});
    wr_type = 3'b010; wr_addr = 32'h304; wr_wstrb = 4'hF; wr_data = {96'd0, 32'h5566_7788};
    wr_req = 1'b1;
    rd_type = 3'b010; rd_addr = 32'h304; rd_req = 1'b1;
    #1;
    check("both_rd_rdy", {31'd0, rd_rdy}, 32'd0);
    check("both_wr_rdy", {31'd0, wr_rdy}, 32'd1);
    step();
    wr_req = 1'b0;
    check("both_T1_rd_rdy", {31'd0, rd_rdy}, 32'd0);
    check("both_T1_vld", {31'd0, ret_valid}, 32'd0);
    step();
    read_chk("raw", 3'b010, 32'h304, 32'h5566_7788, 32'h0, 32'h0, 32'h0, 1);

    // Reset during the second beat of a line read
    rd_type = 3'b100; rd_addr = 32'h100; rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    step();
    check("rstb_beat0", ret_data, 32'hA0);
    step();
    check("rstb_beat1_vld", {31'd0, ret_valid}, 32'd1);
    check("rstb_beat1", ret_data, 32'hA1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstb_idle_rdy", {31'd0, rd_rdy}, 32'd1);
    check("rstb_err", {31'd0, err}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      check("rstb_no_vld", {31'd0, ret_valid}, 32'd0);
      step();
    end

    // Illegal type: served as word, error sticks until reset
    read_chk("illegal", 3'b011, 32'h300, 32'h11AA_3344, 32'h0, 32'h0, 32'h0, 1);
    check("err_set", {31'd0, err}, 32'd1);
    read_chk("after_ill", 3'b100, 32'h200, 32'hD000_0000, 32'hD000_0001,
             32'hD000_0002, 32'hD000_0003, 4);
    check("err_sticky", {31'd0, err}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("err_cleared", {31'd0, err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
